i2c_txn_scheduler: RTL and testbench

Arbiter and sequencer that shares one `i2c_master` instance between up to NREQ client blocks. It grants the bus round-robin and issues the master's one-cycle `start_i2c` pulse. It watches the master's busy and error outputs, retries failed transactions, and resets a hung master on timeout. It sits between the client logic and `i2c_master`; clients never drive the master directly.

---
 rtl/i2c_txn_scheduler.sv | 185 ++++++++++++++++++
 tb/tb_i2c_txn_scheduler.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_txn_scheduler.sv
// Round-robin arbiter/sequencer sharing one i2c_master between NREQ clients,
// with per-transaction retry and hung-master recovery via m_rst.
module i2c_txn_scheduler #(
  parameter int NREQ           = 4,
  parameter int MAX_RETRY      = 2,
  parameter int TIMEOUT_CYCLES = 131072
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [NREQ-1:0] done,
  output logic [NREQ-1:0] fail,
  output logic [3:0]      err_code,
  output logic            busy,
  output logic            m_start,
  input  logic            m_busy,
  input  logic [3:0]      m_error,
  output logic            m_rst,
  output logic [2:0]      o_dbg_state
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_WAIT_ACK  = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_RECOVER   = 3'd4,
    S_RELEASE   = 3'd5
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [PW-1:0]   r_ptr, w_ptr_nxt;
  logic [2:0]      r_retry, w_retry_nxt;
  logic [TW-1:0]   r_tmo, w_tmo_nxt;
  logic [1:0]      r_rec, w_rec_nxt;
  logic [NREQ-1:0] r_gnt, w_gnt_nxt;
  logic [NREQ-1:0] r_done, w_done_nxt;
  logic [NREQ-1:0] r_fail, w_fail_nxt;
  logic [3:0]      r_err, w_err_nxt;
  logic            r_busy, r_mstart, r_mrst;

  logic            w_found;
  logic [PW-1:0]   w_win, w_win_inc;
  logic            w_tmo_hit, w_decide;
  logic [3:0]      w_dec_err;

  // Handshake: a client holds req until its gnt rises; gnt stays high through
  // all retries and drops the cycle after the single done/fail pulse.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!w_found && req[(int'(r_ptr) + i) % NREQ]) begin
        w_found = 1'b1;
        w_win   = PW'((int'(r_ptr) + i) % NREQ);
      end
    end
  end

  assign w_win_inc = (w_win == PW'(NREQ - 1)) ? '0 : w_win + PW'(1);
  // Counter runs from 0 in START, so reaching the limit here puts RECOVER
  // exactly TIMEOUT_CYCLES after the start pulse.
  assign w_tmo_hit = (r_tmo == TW'(TIMEOUT_CYCLES - 1));
  assign w_dec_err = (r_state == S_RECOVER) ? 4'hF : m_error;

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_retry_nxt = r_retry;
    w_tmo_nxt   = r_tmo;
    w_rec_nxt   = r_rec;
    w_gnt_nxt   = r_gnt;
    w_done_nxt  = '0;
    w_fail_nxt  = '0;
    w_err_nxt   = r_err;
    w_decide    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt = S_START;
          w_gnt_nxt   = NREQ'(1) << w_win;
          w_ptr_nxt   = w_win_inc;
          w_retry_nxt = '0;
          w_tmo_nxt   = '0;
        end
      end
      S_START: begin
        w_state_nxt = S_WAIT_ACK;
        w_tmo_nxt   = r_tmo + TW'(1);
      end
      S_WAIT_ACK: begin
        w_tmo_nxt = r_tmo + TW'(1);
        if (w_tmo_hit) begin
          w_state_nxt = S_RECOVER;
          w_rec_nxt   = '0;
        end else if (m_busy) begin
          w_state_nxt = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        w_tmo_nxt = r_tmo + TW'(1);
        if (!m_busy) begin
          w_decide = 1'b1;
        end else if (w_tmo_hit) begin
          w_state_nxt = S_RECOVER;
          w_rec_nxt   = '0;
        end
      end
      S_RECOVER: begin
        w_rec_nxt = r_rec + 2'd1;
        if (r_rec == 2'd3) w_decide = 1'b1;
      end
      S_RELEASE: begin
        w_state_nxt = S_IDLE;
        w_gnt_nxt   = '0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_gnt_nxt   = '0;
      end
    endcase
    if (w_decide) begin
      if (w_dec_err == 4'h0) begin
        w_state_nxt = S_RELEASE;
        w_done_nxt  = r_gnt;
        w_err_nxt   = 4'h0;
      end else if (r_retry < 3'(MAX_RETRY)) begin
        w_state_nxt = S_START;
        w_retry_nxt = r_retry + 3'd1;
        w_tmo_nxt   = '0;
      end else begin
        w_state_nxt = S_RELEASE;
        w_fail_nxt  = r_gnt;
        w_err_nxt   = w_dec_err;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr    <= '0;
      r_retry  <= '0;
      r_tmo    <= '0;
      r_rec    <= '0;
      r_gnt    <= '0;
      r_done   <= '0;
      r_fail   <= '0;
      r_err    <= 4'h0;
      r_busy   <= 1'b0;
      r_mstart <= 1'b0;
      r_mrst   <= 1'b0;
    end else begin
      r_ptr    <= w_ptr_nxt;
      r_retry  <= w_retry_nxt;
      r_tmo    <= w_tmo_nxt;
      r_rec    <= w_rec_nxt;
      r_gnt    <= w_gnt_nxt;
      r_done   <= w_done_nxt;
      r_fail   <= w_fail_nxt;
      r_err    <= w_err_nxt;
      r_busy   <= (w_state_nxt != S_IDLE);
      r_mstart <= (w_state_nxt == S_START);
      r_mrst   <= (w_state_nxt == S_RECOVER);
    end
  end

  assign gnt         = r_gnt;
  assign done        = r_done;
  assign fail        = r_fail;
  assign err_code    = r_err;
  assign busy        = r_busy;
  assign m_start     = r_mstart;
  assign m_rst       = r_mrst;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_i2c_txn_scheduler.sv
// Bench for i2c_txn_scheduler: behavioural i2c master, arbitration/retry model,
// expected-result queue drained by an independent output monitor.
module tb_i2c_txn_scheduler;

  localparam int NREQ      = 4;
  localparam int MAX_RETRY = 2;
  localparam int TMO       = 64;
  localparam int W         = 12;

  typedef struct {
    int         delay;
    int         len;
    logic [3:0] err;
    bit         hang;
  } att_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] gnt, done, fail;
  logic [3:0]      err_code;
  logic            busy, m_start, m_busy, m_rst;
  logic [3:0]      m_error;
  logic [2:0]      dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // expected entry: {starts[11:8], fail[7], client[6:4], err_code[3:0]}
  logic [W-1:0] exp_q[$];
  att_t         plan_q[$];

  logic [NREQ-1:0] pending;
  int              ptr;

  int              n_starts, start_cyc, mrst_len, mon_idx;
  logic [NREQ-1:0] prev_gnt, prev_df, df;
  logic [W-1:0]    got;

  i2c_txn_scheduler #(
    .NREQ(NREQ), .MAX_RETRY(MAX_RETRY), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt), .done(done), .fail(fail),
    .err_code(err_code), .busy(busy), .m_start(m_start), .m_busy(m_busy),
    .m_error(m_error), .m_rst(m_rst), .o_dbg_state(dbg_state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [NREQ-1:0] m, input int p);
    for (int i = 0; i < NREQ; i++)
      if (m[(p + i) % NREQ]) return (p + i) % NREQ;
    return 0;
  endfunction

  task automatic wait_gnt(input bit want, input int limit, input string name);
    int n;
    n = 0;
    while (((gnt != '0) != want) && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(n < limit), 32'd1);
  endtask

  task automatic wait_busy(input bit want, input int limit, input string name);
    int n;
    n = 0;
    while ((m_busy != want) && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(n < limit), 32'd1);
  endtask

  // One transaction: n_bad failing attempts with bad_err, then success if any attempts remain.
  task automatic do_txn(input int n_bad, input logic [3:0] bad_err, input bit hang,
                        input bit keep, input logic [NREQ-1:0] add, input bit last);
    int w;
    int att;
    bit fails;
    w     = pick(pending, ptr);
    ptr   = (w + 1) % NREQ;
    fails = (n_bad > MAX_RETRY);
    att   = fails ? MAX_RETRY + 1 : n_bad + 1;
    for (int a = 0; a < att; a++) begin
      att_t e;
      e.delay = $urandom_range(1, 4);
      e.len   = $urandom_range(1, 10);
      e.err   = (a < n_bad) ? bad_err : 4'h0;
      e.hang  = hang && (a < n_bad);
      plan_q.push_back(e);
    end
    exp_q.push_back({4'(att), fails, 3'(w), fails ? bad_err : 4'h0});
    wait_gnt(1'b1, 200, "gnt_rise");
    chk("gnt_winner", 32'(gnt), 32'(4'b0001 << w));
    if (!keep) pending = (pending & ~(4'b0001 << w)) | add;
    if (last) pending = '0;
    else if (pending == '0) pending = 4'b0001 << $urandom_range(0, 3);
    req = pending;
    wait_gnt(1'b0, 1000, "gnt_fall");
  endtask

  // Behavioural master: busy after `delay` cycles for `len` cycles, or stuck until m_rst.
  initial begin
    m_busy  = 1'b0;
    m_error = 4'h0;
    forever begin
      @(negedge clk);
      if (rst && m_start) begin
        att_t a;
        int   n;
        if (plan_q.size() > 0) a = plan_q.pop_front();
        else a = '{2, 4, 4'h0, 1'b0};
        repeat (a.delay) @(posedge clk);
        #1 m_busy = 1'b1;
        if (a.hang) begin
          n = 0;
          @(negedge clk);
          while (!m_rst && n < 400) begin
            @(negedge clk);
            n++;
          end
          m_busy = 1'b0;
        end else begin
          repeat (a.len) @(posedge clk);
          #1;
          m_busy  = 1'b0;
          m_error = a.err;
        end
      end
    end
  end

  // Output monitor: invariants every cycle, result pop on each done/fail pulse.
  always @(negedge clk) begin
    if (!rst) begin
      n_starts = 0;
      mrst_len = 0;
      prev_gnt = '0;
      prev_df  = '0;
    end else begin
      df = done | fail;
      chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
      chk("pulse_onehot0", 32'($onehot0(df) && ((done & fail) == '0)), 32'd1);
      if (m_start) begin
        n_starts++;
        start_cyc = cyc;
      end
      if (df != '0) begin
        mon_idx = 0;
        for (int i = 0; i < NREQ; i++) if (df[i]) mon_idx = i;
        got = {4'(n_starts), (fail != '0), 3'(mon_idx), err_code};
        chk("pulse_under_gnt", 32'(df), 32'(gnt));
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result actual=%0h expected=none t=%0t", got, $time);
        end else begin
          chk("result", 32'(got), 32'(exp_q.pop_front()));
        end
        n_starts = 0;
      end
      if (prev_gnt != '0 && gnt != prev_gnt) chk("gnt_release", 32'(prev_df), 32'(prev_gnt));
      if (m_rst) begin
        if (mrst_len == 0) chk("mrst_delay", 32'(cyc - start_cyc), 32'(TMO));
        mrst_len++;
      end else if (mrst_len != 0) begin
        chk("mrst_len", 32'(mrst_len), 32'd4);
        mrst_len = 0;
      end
      prev_gnt = gnt;
      prev_df  = df;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst     = 1'b0;
    req     = '0;
    pending = '0;
    ptr     = 0;
    #1;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_fail", 32'(fail), 32'd0);
    chk("rst_err", 32'(err_code), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mstart", 32'(m_start), 32'd0);
    chk("rst_mrst", 32'(m_rst), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // round robin with all four requesting continuously
    pending = 4'hF;
    req     = pending;
    for (int k = 0; k < 8; k++) do_txn(0, 4'h0, 1'b0, 1'b1, 4'h0, k == 7);

    // single request, cycle-exact timing
    @(negedge clk);
    pending = 4'b0100;
    req     = pending;
    ptr     = (pick(pending, ptr) + 1) % NREQ;
    plan_q.push_back('{3, 50, 4'h0, 1'b0});
    exp_q.push_back({4'd1, 1'b0, 3'd2, 4'h0});
    @(negedge clk);
    chk("single_gnt", 32'(gnt), 32'h4);
    chk("single_mstart_hi", 32'(m_start), 32'd1);
    pending = '0;
    req     = '0;
    @(negedge clk);
    chk("single_mstart_lo", 32'(m_start), 32'd0);
    wait_busy(1'b1, 20, "single_busy_rise");
    wait_busy(1'b0, 100, "single_busy_fall");
    @(negedge clk);
    chk("single_done", 32'(done), 32'h4);
    chk("single_err", 32'(err_code), 32'd0);
    chk("single_gnt_held", 32'(gnt), 32'h4);
    @(negedge clk);
    chk("single_gnt_off", 32'(gnt), 32'd0);
    chk("single_idle", 32'(busy), 32'd0);

    // retry then success, retry exhaustion, hung master
    pending = 4'b0001;
    req     = pending;
    do_txn(2, 4'h3, 1'b0, 1'b0, 4'h0, 1'b1);
    pending = 4'b0010;
    req     = pending;
    do_txn(3, 4'h5, 1'b0, 1'b0, 4'h0, 1'b1);
    pending = 4'b1000;
    req     = pending;
    do_txn(3, 4'hF, 1'b1, 1'b0, 4'h0, 1'b1);

    // asynchronous reset in the middle of WAIT_DONE
    @(negedge clk);
    pending = 4'b0100;
    req     = pending;
    plan_q.push_back('{2, 40, 4'h0, 1'b0});
    wait_gnt(1'b1, 20, "mid_gnt_rise");
    pending = '0;
    req     = '0;
    wait_busy(1'b1, 20, "mid_busy_rise");
    repeat (5) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("mid_gnt", 32'(gnt), 32'd0);
    chk("mid_done", 32'(done), 32'd0);
    chk("mid_fail", 32'(fail), 32'd0);
    chk("mid_err", 32'(err_code), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_mstart", 32'(m_start), 32'd0);
    chk("mid_mrst", 32'(m_rst), 32'd0);
    wait_busy(1'b0, 100, "mid_master_drain");
    pending = 4'b1010;
    req     = pending;
    ptr     = 0;
    @(negedge clk);
    rst = 1'b1;
    do_txn(0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0);
    do_txn(0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b1);

    // randomized traffic
    @(negedge clk);
    pending = 4'($urandom_range(1, 15));
    req     = pending;
    for (int k = 0; k < 20; k++)
      do_txn($urandom_range(0, 3), 4'($urandom_range(1, 14)), 1'b0, 1'b0,
             4'($urandom_range(0, 15) & $urandom_range(0, 15)), k == 19);

    repeat (5) @(negedge clk);
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    chk("plan_q_drained", 32'(plan_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
